// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the fetch/data memory arbiter: FSM states, owner tags
// and the byte-enable width.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam int WSTRB_W = 4;

endpackage

// File: rtl/mem_arbiter_arb_prio_streak.sv
// Priority select between fetch and data requesters. Data wins unless fetch
// has been passed over MAX_STREAK times in a row.
module arb_prio_streak #(
  parameter int MAX_STREAK = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_en,
  input  logic i_if_req,
  input  logic i_d_req,
  output logic o_grant_d,
  output logic o_grant_if
);

  localparam int SW = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] MAX_S = SW'(MAX_STREAK);

  logic [SW-1:0] r_streak;
  logic          w_force_if;

  assign w_force_if = i_if_req && (r_streak == MAX_S);
  assign o_grant_d  = i_en && i_d_req && !w_force_if;
  assign o_grant_if = i_en && i_if_req && !o_grant_d;

  // Streak only counts data grants that actually made fetch wait.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_streak <= '0;
    end else if (o_grant_if) begin
      r_streak <= '0;
    end else if (o_grant_d) begin
      if (i_if_req) begin
        if (r_streak != MAX_S) begin
          r_streak <= r_streak + 1'b1;
        end
      end else begin
        r_streak <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port, variable-latency memory bus between instruction
// fetch and load/store, one transaction at a time, with registered bus outputs.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               if_req,
  input  logic [ADDR_W-1:0]  if_addr,
  output logic               if_done,
  output logic [DATA_W-1:0]  if_rdata,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [WSTRB_W-1:0] d_wstrb,
  input  logic [DATA_W-1:0]  d_wdata,
  output logic               d_done,
  output logic [DATA_W-1:0]  d_rdata,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_we,
  output logic [ADDR_W-1:0]  m_addr,
  output logic [WSTRB_W-1:0] m_wstrb,
  output logic [DATA_W-1:0]  m_wdata,
  input  logic               m_rvalid,
  input  logic [DATA_W-1:0]  m_rdata,
  output logic [1:0]         dbg_state
);

  // Bus handshake: a request transfers on the rising edge where m_valid and
  // m_ready are both high; m_* fields hold until then. m_rvalid is a one-cycle
  // response pulse accepted only in WAIT.

  state_t               r_state;
  owner_t               r_owner;
  logic                 r_m_valid;
  logic                 r_m_we;
  logic [ADDR_W-1:0]    r_m_addr;
  logic [WSTRB_W-1:0]   r_m_wstrb;
  logic [DATA_W-1:0]    r_m_wdata;
  logic [DATA_W-1:0]    r_if_rdata;
  logic [DATA_W-1:0]    r_d_rdata;
  logic                 r_if_done;
  logic                 r_d_done;
  logic                 w_grant_en;
  logic                 w_grant_d;
  logic                 w_grant_if;

  // The done cycle is an IDLE where the finishing requester still holds req;
  // granting then would replay the request it just completed.
  assign w_grant_en = (r_state == ST_IDLE) && !r_if_done && !r_d_done;

  arb_prio_streak #(
    .MAX_STREAK (MAX_STREAK)
  ) u_prio (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_en       (w_grant_en),
    .i_if_req   (if_req),
    .i_d_req    (d_req),
    .o_grant_d  (w_grant_d),
    .o_grant_if (w_grant_if)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_owner    <= OWN_IF;
      r_m_valid  <= 1'b0;
      r_m_we     <= 1'b0;
      r_m_addr   <= '0;
      r_m_wstrb  <= '0;
      r_m_wdata  <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_if_done  <= 1'b0;
      r_d_done   <= 1'b0;
    end else begin
      r_if_done <= 1'b0;
      r_d_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_d) begin
            r_owner   <= OWN_D;
            r_m_we    <= d_we;
            r_m_addr  <= d_addr;
            r_m_wstrb <= d_we ? d_wstrb : '0;
            r_m_wdata <= d_wdata;
            r_m_valid <= 1'b1;
            r_state   <= ST_REQ;
          end else if (w_grant_if) begin
            r_owner   <= OWN_IF;
            r_m_we    <= 1'b0;
            r_m_addr  <= if_addr;
            r_m_wstrb <= '0;
            r_m_wdata <= '0;
            r_m_valid <= 1'b1;
            r_state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (m_ready) begin
            r_m_valid <= 1'b0;
            r_state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (m_rvalid) begin
            if (r_owner == OWN_D) begin
              r_d_done <= 1'b1;
              if (!r_m_we) begin
                r_d_rdata <= m_rdata;
              end
            end else begin
              r_if_done  <= 1'b1;
              r_if_rdata <= m_rdata;
            end
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_m_valid <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_valid   = r_m_valid;
  assign m_we      = r_m_we;
  assign m_addr    = r_m_addr;
  assign m_wstrb   = r_m_wstrb;
  assign m_wdata   = r_m_wdata;
  assign if_done   = r_if_done;
  assign if_rdata  = r_if_rdata;
  assign d_done    = r_d_done;
  assign d_rdata   = r_d_rdata;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: bus requests and completions are predicted
// into queues at issue time and checked by independent monitors.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [3:0]  d_wstrb;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        m_valid;
  logic        m_ready;
  logic        m_we;
  logic [31:0] m_addr;
  logic [3:0]  m_wstrb;
  logic [31:0] m_wdata;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic [1:0]  dbg_state;

  logic        resp_rvalid;
  logic [31:0] resp_rdata;
  logic        spur_rvalid;
  int          stall_cycles;
  bit          hold_resp;

  int checks;
  int errors;

  // Completion entry: {port (1 = data), rdata}. Bus entry: {we, wstrb, addr, wdata}.
  logic [32:0] exp_q[$];
  logic [68:0] bus_q[$];
  logic [31:0] exp_if_rdata;
  logic [31:0] exp_d_rdata;

  assign m_rvalid = resp_rvalid | spur_rvalid;
  assign m_rdata  = spur_rvalid ? 32'hBADB_AD00 : resp_rdata;

  mem_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .MAX_STREAK (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_done   (if_done),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wstrb   (d_wstrb),
    .d_wdata   (d_wdata),
    .d_done    (d_done),
    .d_rdata   (d_rdata),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wstrb   (m_wstrb),
    .m_wdata   (m_wdata),
    .m_rvalid  (m_rvalid),
    .m_rdata   (m_rdata),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0000_0013 : (a ^ 32'hCAFE_0000);
  endfunction

  // Driver / prediction tasks
  task automatic exp_fetch(input logic [31:0] a);
    exp_if_rdata = mem_val(a);
    exp_q.push_back({1'b0, exp_if_rdata});
    bus_q.push_back({1'b0, 4'b0000, a, 32'h0});
  endtask

  task automatic exp_load(input logic [31:0] a);
    exp_d_rdata = mem_val(a);
    exp_q.push_back({1'b1, exp_d_rdata});
    bus_q.push_back({1'b0, 4'b0000, a, 32'h0});
  endtask

  task automatic exp_store(input logic [31:0] a, input logic [3:0] s, input logic [31:0] w);
    exp_q.push_back({1'b1, exp_d_rdata});
    bus_q.push_back({1'b1, s, a, w});
  endtask

  task automatic wait_done(input logic port, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if ((port ? d_done : if_done) === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s actual=no_done required=done_within_100_cycles", name);
    end
  endtask

  task automatic do_fetch(input logic [31:0] a, input string name);
    if_addr = a;
    if_req  = 1'b1;
    wait_done(1'b0, name);
    if_req  = 1'b0;
  endtask

  task automatic do_data(input logic we, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] w, input string name);
    d_we    = we;
    d_addr  = a;
    d_wstrb = s;
    d_wdata = w;
    d_req   = 1'b1;
    wait_done(1'b1, name);
    d_req   = 1'b0;
  endtask

  // Memory responder and bus-side monitor
  initial begin
    logic [68:0] snap;
    logic [68:0] e;
    m_ready     = 1'b0;
    resp_rvalid = 1'b0;
    resp_rdata  = '0;
    forever begin
      @(negedge clk);
      if (m_valid === 1'b1) begin
        snap = {m_we, m_wstrb, m_addr, m_wdata};
        if (bus_q.size() == 0) begin
          chk("bus_unexpected_req", {3'b0, snap}, 72'h0);
        end else begin
          e = bus_q.pop_front();
          chk("bus_req", {3'b0, snap}, {3'b0, e});
        end
        for (int i = 0; i < stall_cycles; i++) begin
          @(negedge clk);
          chk("bus_stable", {2'b0, m_valid, m_we, m_wstrb, m_addr, m_wdata}, {2'b0, 1'b1, snap});
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        chk("m_valid_drop", {71'b0, m_valid}, 72'h0);
        if (!hold_resp) begin
          resp_rdata  = mem_val(snap[63:32]);
          resp_rvalid = 1'b1;
          @(posedge clk);
          #1;
          resp_rvalid = 1'b0;
        end
      end
    end
  end

  // Completion scoreboard monitor
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (if_done === 1'b1 || d_done === 1'b1) begin
        if (if_done === 1'b1 && d_done === 1'b1) begin
          chk("both_done", 72'h3, 72'h1);
        end else if (exp_q.size() == 0) begin
          chk("unexpected_done", {70'b0, d_done, if_done}, 72'h0);
        end else begin
          e = exp_q.pop_front();
          if (e[32]) chk("d_done_data", {39'b0, d_done, d_rdata}, {39'b0, 1'b1, e[31:0]});
          else       chk("if_done_data", {39'b0, if_done, if_rdata}, {39'b0, 1'b1, e[31:0]});
        end
      end
    end
  end

  // Stimulus
  initial begin
    checks       = 0;
    errors       = 0;
    reset_n      = 1'b0;
    if_req       = 1'b0;
    if_addr      = '0;
    d_req        = 1'b0;
    d_we         = 1'b0;
    d_addr       = '0;
    d_wstrb      = '0;
    d_wdata      = '0;
    spur_rvalid  = 1'b0;
    stall_cycles = 0;
    hold_resp    = 1'b0;
    exp_if_rdata = '0;
    exp_d_rdata  = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", {71'b0, m_valid}, 72'h0);
    chk("rst_done", {70'b0, if_done, d_done}, 72'h0);
    chk("rst_bus", {3'b0, m_we, m_wstrb, m_addr, m_wdata}, 72'h0);
    chk("rst_rdata", {8'b0, if_rdata, d_rdata}, 72'h0);
    chk("rst_state", {70'b0, dbg_state}, {70'b0, ST_IDLE});
    @(negedge clk);
    reset_n = 1'b1;

    // Fetch only
    @(posedge clk); #1;
    exp_fetch(32'h100);
    do_fetch(32'h100, "fetch_only_done");

    // Store with three stalled request cycles
    repeat (2) @(posedge clk); #1;
    stall_cycles = 3;
    exp_store(32'h2000, 4'b0011, 32'hDEAD_BEEF);
    do_data(1'b1, 32'h2000, 4'b0011, 32'hDEAD_BEEF, "store_done");
    stall_cycles = 0;
    chk("store_d_rdata_kept", {40'b0, d_rdata}, {40'b0, exp_d_rdata});

    // Contention: hand-computed order D,D,D,D,IF,D,D,D,D,IF
    repeat (2) @(posedge clk); #1;
    for (int k = 0; k < 4; k++) exp_load(32'h300 + 4 * k);
    exp_fetch(32'h1000);
    for (int k = 4; k < 8; k++) exp_load(32'h300 + 4 * k);
    exp_fetch(32'h1004);
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          d_we    = 1'b0;
          d_addr  = 32'h300 + 4 * k;
          d_wstrb = 4'b0;
          d_wdata = 32'h0;
          d_req   = 1'b1;
          wait_done(1'b1, "contention_d_done");
        end
        d_req = 1'b0;
      end
      begin
        for (int k = 0; k < 2; k++) begin
          if_addr = 32'h1000 + 4 * k;
          if_req  = 1'b1;
          wait_done(1'b0, "contention_if_done");
        end
        if_req = 1'b0;
      end
    join

    // Simultaneous first request, streak back at zero: data first
    repeat (2) @(posedge clk); #1;
    exp_load(32'h40);
    exp_fetch(32'h0);
    fork
      do_data(1'b0, 32'h40, 4'b0, 32'h0, "simul_d_done");
      do_fetch(32'h0, "simul_if_done");
    join

    // Spurious response while idle
    repeat (2) @(posedge clk); #1;
    spur_rvalid = 1'b1;
    @(posedge clk); #1;
    spur_rvalid = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("spur_if_rdata", {40'b0, if_rdata}, {40'b0, exp_if_rdata});
    chk("spur_d_rdata", {40'b0, d_rdata}, {40'b0, exp_d_rdata});
    chk("spur_state", {70'b0, dbg_state}, {70'b0, ST_IDLE});

    // Asynchronous reset while waiting for the response
    hold_resp = 1'b1;
    bus_q.push_back({1'b0, 4'b0000, 32'h200, 32'h0});
    if_addr = 32'h200;
    if_req  = 1'b1;
    begin
      bit in_wait;
      in_wait = 1'b0;
      for (int i = 0; i < 20 && !in_wait; i++) begin
        @(negedge clk);
        if (dbg_state === ST_WAIT) in_wait = 1'b1;
      end
      chk("reach_wait", {71'b0, in_wait}, 72'h1);
    end
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("arst_m_valid", {71'b0, m_valid}, 72'h0);
    chk("arst_done", {70'b0, if_done, d_done}, 72'h0);
    chk("arst_state", {70'b0, dbg_state}, {70'b0, ST_IDLE});
    chk("arst_rdata", {8'b0, if_rdata, d_rdata}, 72'h0);
    if_req       = 1'b0;
    hold_resp    = 1'b0;
    exp_if_rdata = '0;
    exp_d_rdata  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", {70'b0, dbg_state}, {70'b0, ST_IDLE});
    exp_fetch(32'h100);
    do_fetch(32'h100, "post_rst_fetch_done");

    repeat (5) @(posedge clk); #1;
    chk("exp_q_empty", 72'(exp_q.size()), 72'h0);
    chk("bus_q_empty", 72'(bus_q.size()), 72'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one variable-latency, single-port memory bus between the pipeline's instruction-fetch port and its load/store port.
- Sits between the core and unified memory.
- Returns per-port completion pulses; the core uses these to stall fetch and the memory stage.
- One transaction outstanding at a time. Data side has priority, bounded by an anti-starvation counter.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be 32.
- MAX_STREAK, 4, max consecutive data grants while fetch is pending before fetch is forced.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held until if_done.
- if_addr  in  ADDR_W  fetch address, word aligned.
- if_done  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  DATA_W  fetched instruction; held until next if_done.
- d_req  in  1  data request; held until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wstrb  in  4  byte enables for stores.
- d_wdata  in  DATA_W  store data.
- d_done  out  1  one-cycle pulse: load data valid or store accepted.
- d_rdata  out  DATA_W  load data; held until next d_done.
- m_valid  out  1  memory request valid.
- m_ready  in  1  memory accepts request when m_valid & m_ready.
- m_we  out  1  write.
- m_addr  out  ADDR_W  request address.
- m_wstrb  out  4  byte enables; 4'b0000 on reads.
- m_wdata  out  DATA_W  write data.
- m_rvalid  in  1  response pulse; read data or write acknowledge.
- m_rdata  in  DATA_W  read data.

Behaviour:
- Reset (async assert, sync release) clears:
  - state = IDLE, streak = 0;
  - m_valid, if_done, d_done = 0;
  - m_addr, m_wdata, m_wstrb, m_we, if_rdata, d_rdata = 0.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - If any request is present, select an owner and go to REQ.
  - Owner = data if d_req and not (if_req and streak == MAX_STREAK); otherwise fetch if if_req.
  - No request: stay in IDLE.
- Capture on entering REQ:
  - addr, we, wstrb and wdata of the owner are registered.
  - Fetch requests use we = 0 and wstrb = 0.
- REQ:
  - m_valid = 1; all m_* fields stay stable until the handshake.
  - On m_valid & m_ready: go to WAIT; m_valid drops the next cycle.
- WAIT:
  - On m_rvalid: pulse the owner's done signal for exactly one cycle, in the cycle after m_rvalid.
  - On a read, latch m_rdata into the owner's rdata register.
  - Return to IDLE.
  - Minimum latency, request to done: 3 cycles with zero-wait memory.
- No back-to-back shortcut: IDLE always separates transactions. The requester's done cycle overlaps that IDLE; the requester deasserts req on the cycle after done.
- Streak counter:
  - Increments on each data grant made while if_req = 1, saturating at MAX_STREAK.
  - Resets to 0 on any fetch grant.
  - Resets to 0 on a data grant made while if_req = 0.
- Simultaneous if_req and d_req in IDLE: data wins unless streak == MAX_STREAK.
- Requester drops req mid-transaction: protocol violation. The arbiter still completes the bus transaction and still pulses done.
- m_rvalid outside WAIT: ignored.
- Reset mid-transaction: returns to IDLE immediately, drops m_valid, no done pulse. The memory side is reset by the same reset_n.
- Grant decisions use the registered streak only; no combinational path from m_* inputs to m_* outputs.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2);
  - owner encoding (OWN_IF = 1'b0, OWN_D = 1'b1);
  - the WSTRB_W = 4 constant.
- One natural sub-module: arb_prio_streak. It contains the priority-select logic plus the streak counter, and outputs grant_d / grant_if.
- FSM and bus registers stay in the top module.

Test Plan:
- Fetch only: if_req, if_addr = 0x100, m_ready = 1, m_rvalid one cycle after accept with 0x00000013 → single m_valid cycle with addr 0x100, we = 0, wstrb = 0; if_done pulses once; if_rdata = 0x00000013.
- Store with wait states: d_req, d_we = 1, addr 0x2000, wstrb 4'b0011, wdata 0xDEADBEEF, m_ready low for 3 cycles → m_* fields stable through all 3 stalled cycles; one d_done after m_rvalid; d_rdata unchanged.
- Contention: if_req and d_req both held continuously, MAX_STREAK = 4 → grant order D, D, D, D, IF, D, D, D, D, IF; never 5 consecutive D grants.
- Simultaneous first request with streak = 0: d_req (load, addr 0x40) and if_req (addr 0x0) → data served first; fetch served next; d_done precedes if_done.
- Async reset: assert reset_n = 0 mid-WAIT, between clock edges → m_valid, if_done, d_done go 0 without waiting for an edge; no done pulse; after release, the next request starts from IDLE.
- Spurious m_rvalid while IDLE → no done pulse; rdata registers unchanged.
